// File: rtl/ksa_pkg.sv
// Shared definitions for the pipelined Kogge-Stone adder: op encoding,
// parameter legality and the mapping of pipeline positions to register stages.
package ksa_pkg;

  localparam logic KSA_ADD = 1'b0;
  localparam logic KSA_SUB = 1'b1;

  function automatic bit ksa_params_ok(input int width, input int stages);
    int lg;
    lg = $clog2(width);
    return (width >= 4) && (width <= 64) && ((width & (width - 1)) == 0) &&
           (stages >= 1) && (stages <= lg + 1);
  endfunction

  // Position pos < levels feeds prefix level pos; pos == levels feeds the sum XOR.
  // Consecutive positions differ by at most one segment, so each change is one register.
  function automatic int ksa_pos_seg(input int pos, input int levels, input int stages);
    if (pos < levels) return (pos * stages) / levels;
    return stages - 1;
  endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// One Kogge-Stone prefix level: combines each (G,P) pair with the pair SPAN bits below.
module ksa_prefix_level #(
  parameter int WIDTH = 16,
  parameter int SPAN  = 1
) (
  input  logic [WIDTH-1:0] i_g,
  input  logic [WIDTH-1:0] i_p,
  output logic [WIDTH-1:0] o_g,
  output logic [WIDTH-1:0] o_p
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_g;
    logic w_p;
    if (i >= SPAN) begin : g_comb
      assign w_g = i_g[i] | (i_p[i] & i_g[i-SPAN]);
      assign w_p = i_p[i] & i_p[i-SPAN];
    end else begin : g_pass
      assign w_g = i_g[i];
      assign w_p = i_p[i];
    end
    assign o_g[i] = w_g;
    assign o_p[i] = w_p;
  end

endmodule

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone add/subtract with valid/ready flow control, a sideband
// tag and an optional reference adder carried alongside for self-checking.
module ksa_pipe
  import ksa_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int STAGES   = 3,
  parameter int TAG_W    = 4,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             op,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [TAG_W-1:0] tag_out,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             mismatch,
  output logic [15:0]      err_cnt
);

  localparam int LVLS   = $clog2(WIDTH);
  localparam int PR_LO  = 2 * WIDTH;
  localparam int CIN_B  = 3 * WIDTH;
  localparam int TAG_LO = 3 * WIDTH + 1;
  localparam int REF_LO = 3 * WIDTH + 1 + TAG_W;
  localparam int BW     = 4 * WIDTH + TAG_W + 2;

  if (!ksa_params_ok(WIDTH, STAGES)) begin : g_param_chk
    $fatal(1, "ksa_pipe: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
  end

  // Bus layout: {ref, tag, cin, p_raw, p, g}
  logic [BW-1:0]     w_pre  [LVLS+1];
  logic [BW-1:0]     w_post [LVLS+1];
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] w_rdy;
  logic [STAGES-1:0] w_vin;

  logic [WIDTH-1:0]  w_b_eff;
  logic              w_cin_eff;
  logic [WIDTH-1:0]  w_p0;
  logic [WIDTH-1:0]  w_g0;
  logic [WIDTH:0]    w_ref;

  assign w_b_eff   = (op == KSA_SUB) ? ~B : B;
  assign w_cin_eff = (op == KSA_SUB) ? 1'b1 : Cin;
  assign w_p0      = A ^ w_b_eff;
  // Carry-in folded into bit 0's generate keeps the tree at exactly LVLS levels.
  assign w_g0      = (A & w_b_eff) | {{(WIDTH-1){1'b0}}, w_p0[0] & w_cin_eff};

  if (CHECK_EN) begin : g_ref
    assign w_ref = {1'b0, A} + {1'b0, w_b_eff} + (WIDTH+1)'(w_cin_eff);
  end else begin : g_noref
    assign w_ref = '0;
  end

  assign w_pre[0] = {w_ref, tag_in, w_cin_eff, w_p0, w_p0, w_g0};

  always_comb begin
    logic v_full;
    v_full = 1'b1;
    w_rdy  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      v_full   = v_full & r_vld[k];
      w_rdy[k] = out_rdy | ~v_full;
    end
  end

  always_comb begin
    w_vin    = '0;
    w_vin[0] = in_vld;
    for (int k = 1; k < STAGES; k++) w_vin[k] = r_vld[k-1];
  end

  assign in_rdy = w_rdy[0] & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) r_vld[k] <= w_vin[k];
      end
    end
  end

  for (genvar n = 0; n <= LVLS; n++) begin : g_pos
    localparam int SEG      = ksa_pos_seg(n, LVLS, STAGES);
    localparam int SEG_PREV = (n == 0) ? 0 : ksa_pos_seg(n - 1, LVLS, STAGES);
    if (SEG != SEG_PREV) begin : g_cut
      logic [BW-1:0] r_bus;
      always_ff @(posedge clk) begin
        if (w_rdy[SEG_PREV] && w_vin[SEG_PREV]) r_bus <= w_pre[n];
      end
      assign w_post[n] = r_bus;
    end else begin : g_thru
      assign w_post[n] = w_pre[n];
    end
  end

  for (genvar k = 0; k < LVLS; k++) begin : g_lvl
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    ksa_prefix_level #(
      .WIDTH (WIDTH),
      .SPAN  (1 << k)
    ) u_lvl (
      .i_g (w_post[k][WIDTH-1:0]),
      .i_p (w_post[k][2*WIDTH-1:WIDTH]),
      .o_g (w_g),
      .o_p (w_p)
    );
    assign w_pre[k+1] = {w_post[k][BW-1:PR_LO], w_p, w_g};
  end

  logic [WIDTH-1:0] w_gf;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [TAG_W-1:0] r_tag;
  logic [WIDTH:0]   r_ref;
  logic [15:0]      r_err_cnt;

  assign w_gf  = w_post[LVLS][WIDTH-1:0];
  assign w_sum = w_post[LVLS][CIN_B-1:PR_LO] ^ {w_gf[WIDTH-2:0], w_post[LVLS][CIN_B]};

  always_ff @(posedge clk) begin
    if (w_rdy[STAGES-1] && w_vin[STAGES-1]) begin
      r_sum  <= w_sum;
      r_cout <= w_gf[WIDTH-1];
      r_tag  <= w_post[LVLS][REF_LO-1:TAG_LO];
      r_ref  <= w_post[LVLS][BW-1:REF_LO];
    end
  end

  assign Sum      = r_sum;
  assign Cout     = r_cout;
  assign tag_out  = r_tag;
  assign out_vld  = r_vld[STAGES-1];
  assign mismatch = CHECK_EN ? (out_vld && ({r_cout, r_sum} != r_ref)) : 1'b0;
  assign err_cnt  = r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (out_vld && out_rdy && mismatch && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ksa_pipe.sv
// Directed bench for ksa_pipe at WIDTH=16, STAGES=3: latency, add/sub results,
// backpressure ordering, mid-flight reset, a short random stream and a forced fault.
module tb_ksa_pipe;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        op;
  logic [3:0]  tag_in;
  logic        in_vld;
  logic        in_rdy;
  logic [15:0] Sum;
  logic        Cout;
  logic [3:0]  tag_out;
  logic        out_vld;
  logic        out_rdy;
  logic        mismatch;
  logic [15:0] err_cnt;

  int n_tests;
  int n_fail;

  typedef struct packed {
    logic [3:0]  t;
    logic [16:0] r;
  } exp_t;
  exp_t q[$];

  logic [15:0] fa [4] = '{16'h000C, 16'h0001, 16'h0008, 16'h0010};
  logic [15:0] fb [4] = '{16'h0004, 16'h0001, 16'h0008, 16'h0020};
  logic [15:0] fs [4] = '{16'h0000, 16'h0002, 16'h0000, 16'h0030};
  logic        fm [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  ksa_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .op       (op),
    .tag_in   (tag_in),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .Sum      (Sum),
    .Cout     (Cout),
    .tag_out  (tag_out),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .mismatch (mismatch),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic o, input logic [15:0] a, input logic [15:0] b,
                                        input logic ci);
    if (o) return {1'b0, a} + {1'b0, ~b} + 17'd1;
    return {1'b0, a} + {1'b0, b} + {16'd0, ci};
  endfunction

  // Entered just after a rising edge with the pipe empty and out_rdy=1.
  task automatic run_op(input string nm, input logic o, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic [3:0] t, input logic [15:0] es, input logic ec);
    int lat;
    op = o; A = a; B = b; Cin = ci; tag_in = t; in_vld = 1'b1;
    @(negedge clk);
    check({nm, "_in_rdy"}, 32'(in_rdy), 32'd1);
    @(posedge clk); #1;
    in_vld = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_vld && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'd3);
    check({nm, "_sum"}, 32'(Sum), 32'(es));
    check({nm, "_cout"}, 32'(Cout), 32'(ec));
    check({nm, "_tag"}, 32'(tag_out), 32'(t));
    check({nm, "_mismatch"}, 32'(mismatch), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int   idx;
    int   acc;
    int   got;
    int   cyc;
    int   seen;
    int   nsent;
    int   nrecv;
    logic rdy_s;
    logic do_in;
    logic do_out;
    exp_t e;

    n_tests = 0; n_fail = 0;
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
    A = '0; B = '0; Cin = 1'b0; op = 1'b0; tag_in = '0;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_in_rdy", 32'(in_rdy), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_rdy", 32'(in_rdy), 32'd1);
    @(posedge clk); #1;

    run_op("add_ffff_1",  1'b0, 16'hFFFF, 16'h0001, 1'b0, 4'h1, 16'h0000, 1'b1);
    run_op("sub_5_7",     1'b1, 16'h0005, 16'h0007, 1'b1, 4'h2, 16'hFFFE, 1'b0);
    run_op("sub_7_5",     1'b1, 16'h0007, 16'h0005, 1'b0, 4'h3, 16'h0002, 1'b1);
    run_op("add_cin",     1'b0, 16'h1234, 16'h4321, 1'b1, 4'h4, 16'h5556, 1'b0);
    run_op("add_msb",     1'b0, 16'h8000, 16'h8000, 1'b1, 4'h5, 16'h0001, 1'b1);
    run_op("add_zero_ci", 1'b0, 16'h0000, 16'h0000, 1'b1, 4'h6, 16'h0001, 1'b0);
    run_op("sub_0_0",     1'b1, 16'h0000, 16'h0000, 1'b0, 4'h7, 16'h0000, 1'b1);
    run_op("add_chain8",  1'b0, 16'h00FF, 16'h0F01, 1'b0, 4'h8, 16'h1000, 1'b0);
    run_op("add_prop16",  1'b0, 16'hAAAA, 16'h5555, 1'b1, 4'h9, 16'h0000, 1'b1);

    // Backpressure: out_rdy low for 10 cycles with in_vld held high.
    out_rdy = 1'b0; idx = 0; acc = 0; in_vld = 1'b1; op = 1'b0; Cin = 1'b0; B = 16'h0100;
    for (int c = 0; c < 10; c++) begin
      tag_in = idx[3:0]; A = 16'(idx);
      @(negedge clk);
      rdy_s = in_rdy;
      @(posedge clk); #1;
      if (rdy_s) begin idx++; acc++; end
    end
    @(negedge clk);
    check("bp_accepts", 32'(acc), 32'd3);
    check("bp_in_rdy_full", 32'(in_rdy), 32'd0);
    check("bp_hold_vld", 32'(out_vld), 32'd1);
    check("bp_hold_tag", 32'(tag_out), 32'd0);
    check("bp_hold_sum", 32'(Sum), 32'h0100);
    @(posedge clk); #1;

    out_rdy = 1'b1; got = 0; cyc = 0;
    while (got < 10 && cyc < 100) begin
      if (idx < 10) begin
        in_vld = 1'b1; tag_in = idx[3:0]; A = 16'(idx);
      end else begin
        in_vld = 1'b0;
      end
      @(negedge clk);
      rdy_s = in_rdy;
      if (cyc == 0) check("bp_full_pass_in_rdy", 32'(in_rdy), 32'd1);
      if (out_vld) begin
        check("bp_order_tag", 32'(tag_out), 32'(got));
        check("bp_order_sum", 32'(Sum), 32'h0100 + 32'(got));
        got++;
      end
      @(posedge clk); #1;
      if (rdy_s && in_vld) idx++;
      cyc++;
    end
    in_vld = 1'b0;
    check("bp_out_count", 32'(got), 32'd10);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_drained", 32'(out_vld), 32'd0);
    @(posedge clk); #1;

    // Reset with three operations in flight.
    out_rdy = 1'b0; in_vld = 1'b1; op = 1'b0; Cin = 1'b0; B = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      tag_in = 4'hA + 4'(i); A = 16'(i);
      @(posedge clk); #1;
    end
    in_vld = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rstmid_in_rdy", 32'(in_rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_out_vld", 32'(out_vld), 32'd0);
    check("rstmid_err_cnt", 32'(err_cnt), 32'd0);
    check("rstmid_in_rdy_after", 32'(in_rdy), 32'd1);
    @(posedge clk); #1;
    out_rdy = 1'b1; seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_vld) seen++;
      @(posedge clk); #1;
    end
    check("rstmid_no_output", 32'(seen), 32'd0);

    // Short random stream with random valid and backpressure.
    nsent = 0; nrecv = 0; cyc = 0;
    while (nrecv < 64 && cyc < 2000) begin
      in_vld  = (nsent < 64) && ($urandom_range(0, 3) != 0);
      A       = 16'($urandom);
      B       = 16'($urandom);
      Cin     = 1'($urandom);
      op      = 1'($urandom);
      tag_in  = nsent[3:0];
      out_rdy = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      do_in  = in_vld && in_rdy;
      do_out = out_vld && out_rdy;
      if (do_out) begin
        check("rnd_queue_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("rnd_tag", 32'(tag_out), 32'(e.t));
          check("rnd_result", 32'({Cout, Sum}), 32'(e.r));
          check("rnd_mismatch", 32'(mismatch), 32'd0);
        end
        nrecv++;
      end
      if (do_in) begin
        q.push_back('{t: tag_in, r: model(op, A, B, Cin)});
        nsent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    check("rnd_received", 32'(nrecv), 32'd64);
    check("rnd_err_cnt", 32'(err_cnt), 32'd0);
    repeat (4) @(posedge clk);
    #1;

    // Level-0 group generate of bit 3 stuck at 0: ops 0 and 2 are affected.
    force dut.g_lvl[0].u_lvl.g_bit[3].w_g = 1'b0;
    idx = 0; got = 0; op = 1'b0; Cin = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (idx < 4) begin
        in_vld = 1'b1; A = fa[idx]; B = fb[idx];
      end else begin
        in_vld = 1'b0;
      end
      tag_in = idx[3:0];
      @(negedge clk);
      rdy_s = in_rdy;
      if (out_vld && got < 4) begin
        check("fault_mismatch", 32'(mismatch), 32'(fm[got]));
        check("fault_sum", 32'(Sum), 32'(fs[got]));
        got++;
      end
      @(posedge clk); #1;
      if (rdy_s && in_vld) idx++;
    end
    release dut.g_lvl[0].u_lvl.g_bit[3].w_g;
    in_vld = 1'b0;
    check("fault_out_count", 32'(got), 32'd4);
    check("fault_err_cnt", 32'(err_cnt), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
